// File: rtl/wb_release_unit_pkg.sv
// Shared constants, buffer entry type and register one-hot helper for the
// writeback/release unit. Register count and data width are fixed here.
package wb_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NREG      = 32;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic                 full;
    logic [REG_IDX_W-1:0] rd;
    logic                 wen;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

  function automatic logic [NREG-1:0] onehot_reg(input logic [REG_IDX_W-1:0] rd);
    logic [NREG-1:0] m;
    m     = {NREG{1'b0}};
    m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_release_unit_if.sv
// FU result handshake, register-file write port and scoreboard release bus.
// The master side is the FU array / environment, the slave side is the unit.
interface wb_release_unit_if
  import wb_pkg::*;
#(
  parameter int NUM_FU = 4
);

  logic [NUM_FU-1:0]                fu_valid;
  logic [NUM_FU-1:0]                fu_ready;
  logic [NUM_FU-1:0][REG_IDX_W-1:0] fu_rd;
  logic [NUM_FU-1:0]                fu_wen;
  logic [NUM_FU-1:0][XLEN-1:0]      fu_data;
  logic                             flush;
  logic                             rf_we;
  logic [REG_IDX_W-1:0]             rf_waddr;
  logic [XLEN-1:0]                  rf_wdata;
  logic [NREG-1:0]                  rel_mask;
  logic                             busy;
  logic [31:0]                      perf_wb_cnt;
  logic [31:0]                      perf_conflict_cnt;

  modport slave (
    input  fu_valid, fu_rd, fu_wen, fu_data, flush,
    output fu_ready, rf_we, rf_waddr, rf_wdata, rel_mask, busy,
           perf_wb_cnt, perf_conflict_cnt
  );

  modport master (
    output fu_valid, fu_rd, fu_wen, fu_data, flush,
    input  fu_ready, rf_we, rf_waddr, rf_wdata, rel_mask, busy,
           perf_wb_cnt, perf_conflict_cnt
  );

endinterface

// File: rtl/wb_release_unit_chk.sv
// Simulation-only protocol checker: two live buffers must never target the
// same non-zero destination register (the issue scoreboard prevents WAW).
module wb_release_unit_chk
  import wb_pkg::*;
#(
  parameter int NUM_FU = 4
) (
  input logic                             clk,
  input logic                             rst,
  input logic [NUM_FU-1:0]                full,
  input logic [NUM_FU-1:0][REG_IDX_W-1:0] rd
);

  for (genvar i = 0; i < NUM_FU; i++) begin : g_i
    for (genvar j = i + 1; j < NUM_FU; j++) begin : g_j
      no_waw: assert property (@(posedge clk) disable iff (rst)
        !(full[i] && full[j] && (rd[i] == rd[j]) && (rd[i] != {REG_IDX_W{1'b0}})));
    end
  end

endmodule

// File: rtl/wb_release_unit_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer; the pointer moves past the winner on advance and zeroes on clear.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  input  logic         clear,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] next_ptr;

  // Rotating-priority search beginning at ptr
  always_comb begin
    int   idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    grant    = {N{1'b0}};
    next_ptr = ptr;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = PW'((idx + 1) % N);
      end else begin
        found = found;
      end
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr <= {PW{1'b0}};
    end else if (advance) begin
      ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/wb_release_unit.sv
// Writeback/release unit: per-FU result buffers, round-robin register-file
// write and scoreboard release pulses. Optional counters: WB_PERF_CNT_EN.
module wb_release_unit
  import wb_pkg::*;
#(
  parameter int NUM_FU = 4
) (
  input logic              clk,
  input logic              rst,
  wb_release_unit_if.slave bus
);

  wb_entry_t [NUM_FU-1:0]           entries;
  logic [NUM_FU-1:0]                full;
  logic [NUM_FU-1:0][REG_IDX_W-1:0] ent_rd;
  logic [NUM_FU-1:0]                grant;
  logic [NUM_FU-1:0]                ready;
  logic [NUM_FU-1:0]                take;
  wb_entry_t                        win;
  logic [NREG-1:0]                  kill_mask;

  // Unpack buffer state for the arbiter and checker
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      full[i]   = entries[i].full;
      ent_rd[i] = entries[i].rd;
    end
  end

  rr_arbiter #(.N(NUM_FU)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (full),
    .advance ((|grant) & ~bus.flush),
    .clear   (bus.flush),
    .grant   (grant)
  );

  // Handshake, winning entry, and the release mask for everything a flush kills
  always_comb begin
    win       = '0;
    kill_mask = {NREG{1'b0}};
    ready     = ~full | grant | {NUM_FU{bus.flush}};
    take      = bus.fu_valid & ready;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        win = entries[i];
      end else begin
        win = win;
      end
      kill_mask = kill_mask
                | (entries[i].full ? onehot_reg(entries[i].rd) : {NREG{1'b0}})
                | (bus.fu_valid[i] ? onehot_reg(bus.fu_rd[i]) : {NREG{1'b0}});
    end
    bus.fu_ready = ready;
    bus.busy     = |full;
  end

  // Buffer fill/drain and registered writeback/release outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      entries      <= '0;
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= {REG_IDX_W{1'b0}};
      bus.rf_wdata <= {XLEN{1'b0}};
      bus.rel_mask <= {NREG{1'b0}};
    end else if (bus.flush) begin
      entries      <= '0;
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= {REG_IDX_W{1'b0}};
      bus.rf_wdata <= {XLEN{1'b0}};
      bus.rel_mask <= kill_mask;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (take[i]) begin
          entries[i] <= '{full: 1'b1, rd: bus.fu_rd[i], wen: bus.fu_wen[i],
                          data: bus.fu_data[i]};
        end else if (grant[i]) begin
          entries[i].full <= 1'b0;
        end
      end
      bus.rf_we    <= win.full & win.wen & (win.rd != {REG_IDX_W{1'b0}});
      bus.rf_waddr <= win.rd;
      bus.rf_wdata <= win.data;
      bus.rel_mask <= win.full ? onehot_reg(win.rd) : {NREG{1'b0}};
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [31:0] wb_cnt;
  logic [31:0] conflict_cnt;

  // Event counters; flush cycles count toward neither
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_cnt       <= 32'd0;
      conflict_cnt <= 32'd0;
    end else if (!bus.flush) begin
      if (win.full) begin
        wb_cnt <= wb_cnt + 32'd1;
      end
      if ($countones(full) > 1) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
    end
  end

  assign bus.perf_wb_cnt       = wb_cnt;
  assign bus.perf_conflict_cnt = conflict_cnt;
`else
  assign bus.perf_wb_cnt       = 32'd0;
  assign bus.perf_conflict_cnt = 32'd0;
`endif

  wb_release_unit_chk #(.NUM_FU(NUM_FU)) u_chk (
    .clk  (clk),
    .rst  (rst),
    .full (full),
    .rd   (ent_rd)
  );

endmodule

// File: doc/wb_release_unit.md
Name: wb_release_unit

Overview:
Writeback and release end of the register-scoreboard protocol. Function units (FUs) hand completed results to this block. It buffers them, arbitrates one register-file write per cycle, and returns per-register release pulses so the issue-side scoreboard can clear pending bits and drop its stall. It sits between the FU outputs and the register file write port, and drives the scoreboard's clear inputs.

Parameters:
NUM_FU, 4, number of FU result ports (2..8)
XLEN, 32, result data width
NREG, 32, architectural register count; register index width is $clog2(NREG)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
fu_valid  in  NUM_FU  per-FU result valid
fu_ready  out  NUM_FU  per-FU buffer can accept
fu_rd  in  NUM_FU x 5  destination register per FU
fu_wen  in  NUM_FU  result writes rd (0 for branch/store: release only)
fu_data  in  NUM_FU x XLEN  result data
flush  in  1  kill all buffered and incoming results (taken-branch redirect)
rf_we  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  XLEN  register-file write data
rel_mask  out  NREG  one-hot-or-multi release bits to scoreboard; bit r = clear pending[r]
busy  out  1  any FU buffer occupied
perf_wb_cnt  out  32  writebacks performed (see Optional Feature)
perf_conflict_cnt  out  32  cycles with more than one full buffer (see Optional Feature)

Behaviour:
- State:
  - One entry per FU: full, rd, wen, data.
  - Round-robin pointer rr_ptr.
  - Registered outputs rf_we, rf_waddr, rf_wdata, rel_mask.
- Reset (rst=1 at posedge):
  - All buffers empty; rr_ptr=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, rel_mask=0, busy=0, perf counters=0.
  - Reset mid-operation discards buffered results with no write and no release.
- Accept:
  - fu_ready[i] = !full[i] | grant[i] | flush.
  - Transfer on fu_valid[i] & fu_ready[i]; the buffer is full from the next cycle.
  - A drain and a refill in the same cycle give 1 result/cycle/FU throughput.
- Arbitrate (combinational on buffer state):
  - Pick the first full buffer at or after rr_ptr, wrapping modulo NUM_FU.
  - At most one grant per cycle.
  - On grant i, rr_ptr <= (i+1) mod NUM_FU. With no grant, rr_ptr holds.
- Outputs (registered; asserted the cycle after grant):
  - rf_we = wen & (rd!=0).
  - rf_waddr = rd; rf_wdata = data.
  - rel_mask = one-hot(rd), asserted even when wen=0 or rd=0.
  - All output bits are single-cycle pulses, 0 when idle.
- Latency: FU handshake in cycle N, grant in N+1, rf_we/rel_mask high in N+2 (minimum).
- Flush (at posedge with flush=1):
  - All full buffers and all valid incoming FU results are discarded.
  - No rf_we is issued for them.
  - rel_mask next cycle = OR of one-hot(rd) over every discarded entry, so the scoreboard never strands a pending bit.
  - Any grant in the flush cycle is also suppressed; its rd is included in the mask.
  - rr_ptr resets to 0.
- busy = OR(full[]).
- Illegal input: two live entries with the same rd (WAW) cannot occur, because the scoreboard stalls on pending rd. Simulation-only assertion flags it.

Optional Feature:
WB_PERF_CNT_EN:
- Defined: perf_wb_cnt increments on each output cycle with rel_mask!=0 that is not a flush cycle. perf_conflict_cnt increments each cycle with popcount(full)>1 and flush=0. Both wrap at 2^32 and are cleared by rst.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package wb_pkg holds:
  - Constants REG_IDX_W=5 and NREG.
  - Typedef wb_entry_t {full, rd, wen, data}.
  - Function onehot_reg(rd) returning NREG bits.
- Sub-module rr_arbiter (NUM_FU request in, one-hot grant out, pointer register, advance input).

Test Plan:
1. Reset: assert rst 2 cycles -> rf_we=0, rel_mask=0, busy=0, fu_ready=all 1.
2. Single FU0 result rd=5, wen=1, data=0xDEADBEEF at cycle N -> cycle N+2: rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, rel_mask=1<<5; next cycle all 0.
3. FU0..FU3 all valid same cycle with rd=1,2,3,4 -> writes in order rd 1,2,3,4 on 4 consecutive cycles; perf_conflict_cnt=3 with WB_PERF_CNT_EN.
4. Store-like result FU2 rd=0, wen=0 and branch rd=7, wen=0 -> rf_we stays 0; rel_mask=1<<0 then 1<<7.
5. Buffers hold rd=3 (FU1) and rd=9 (FU2), FU0 valid rd=12, flush=1 -> next cycle rf_we=0, rel_mask=(1<<3)|(1<<9)|(1<<12), busy=0.
6. FU1 valid every cycle for 8 cycles with the other FUs idle -> fu_ready[1] stays 1; 8 back-to-back writes; perf_wb_cnt=8.
